// File: rtl/tlb_pkg.sv
// Shared types and constants for the fully-associative TLB.
package tlb_pkg;

  localparam logic [3:0] SATP_MODE_BARE = 4'h0;
  localparam logic [1:0] PRIV_M         = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [26:0] tag;   // vaddr[38:12]
    logic [43:0] ppn;   // paddr[55:12]
  } tlb_entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWreq,
    StWwait,
    StDone
  } tlb_state_t;

  // Physical address from a cached/returned PPN and the request's page offset.
  function automatic logic [63:0] make_paddr(input logic [43:0] ppn, input logic [11:0] off);
    return {8'b0, ppn, off};
  endfunction

endpackage

// File: rtl/tlb_if.sv
// Pipeline-side and walker-side signals of the TLB bundled into one interface.
interface tlb_if;
  logic        req_valid;
  logic [63:0] req_vaddr;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic [3:0]  satp_mode;
  logic [1:0]  priviledgeMode;
  logic        flush;
  logic        walk_req_valid;
  logic [63:0] walk_vaddr;
  logic        walk_resp_valid;
  logic [63:0] walk_resp_paddr;

  // TLB side
  modport slave (
    input  req_valid, req_vaddr, satp_mode, priviledgeMode, flush,
    input  walk_resp_valid, walk_resp_paddr,
    output resp_valid, resp_paddr, walk_req_valid, walk_vaddr
  );

  // Pipeline + walker side
  modport master (
    output req_valid, req_vaddr, satp_mode, priviledgeMode, flush,
    output walk_resp_valid, walk_resp_paddr,
    input  resp_valid, resp_paddr, walk_req_valid, walk_vaddr
  );
endinterface

// File: rtl/tlb_victim_sel.sv
// Replacement victim: lowest-index invalid entry, otherwise the round-robin pointer.
module tlb_victim_sel #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   victim_o,
  output logic               use_rr_o
);

  // Scan downwards so the lowest invalid index is the last one written.
  always_comb begin
    victim_o = rr_ptr_i;
    use_rr_o = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        victim_o = IDX_W'(i);
        use_rr_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// Fully-associative TLB in front of the Sv39 walker; bypasses in bare mode or M-mode.
module tlb
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input logic clk,
  input logic reset,
  tlb_if.slave bus
);

  tlb_state_t        state_q, state_d;
  logic [63:0]       vaddr_q, vaddr_d;
  tlb_entry_t        entries_q [ENTRIES];
  tlb_entry_t        entries_d [ENTRIES];
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              flush_pend_q, flush_pend_d;
  logic [63:0]       resp_paddr_q, resp_paddr_d;
  logic [63:0]       walk_vaddr_q, walk_vaddr_d;

  logic [ENTRIES-1:0] valid_vec;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   victim_idx;
  logic               victim_is_rr;
  logic               unused_paddr_bits;

  assign unused_paddr_bits = ^{bus.walk_resp_paddr[63:56], bus.walk_resp_paddr[11:0]};

  // Parallel tag compare; lowest index wins on the (impossible) multi-hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && entries_q[i].tag == vaddr_q[38:12]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  tlb_victim_sel #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W)
  ) u_victim_sel (
    .valid_i (valid_vec),
    .rr_ptr_i(rr_ptr_q),
    .victim_o(victim_idx),
    .use_rr_o(victim_is_rr)
  );

  // Next-state, fill and flush logic.
  always_comb begin
    state_d      = state_q;
    vaddr_d      = vaddr_q;
    entries_d    = entries_q;
    rr_ptr_d     = rr_ptr_q;
    flush_pend_d = flush_pend_q;
    resp_paddr_d = resp_paddr_q;
    walk_vaddr_d = walk_vaddr_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          vaddr_d = bus.req_vaddr;
          if (bus.satp_mode == SATP_MODE_BARE || bus.priviledgeMode == PRIV_M) begin
            resp_paddr_d = bus.req_vaddr;
            state_d      = StDone;
          end else begin
            state_d = StLookup;
          end
        end
      end
      StLookup: begin
        if (hit) begin
          resp_paddr_d = make_paddr(entries_q[hit_idx].ppn, vaddr_q[11:0]);
          state_d      = StDone;
        end else begin
          walk_vaddr_d = vaddr_q;
          state_d      = StWreq;
        end
      end
      StWreq: begin
        if (bus.flush) flush_pend_d = 1'b1;
        state_d = StWwait;
      end
      StWwait: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.walk_resp_valid) begin
          resp_paddr_d = make_paddr(bus.walk_resp_paddr[55:12], vaddr_q[11:0]);
          // A flush seen during the walk makes its result stale for caching.
          if (!flush_pend_q && !bus.flush) begin
            entries_d[victim_idx] = '{valid: 1'b1, tag: vaddr_q[38:12],
                                      ppn: bus.walk_resp_paddr[55:12]};
            if (victim_is_rr) rr_ptr_d = rr_ptr_q + IDX_W'(1);
          end
          flush_pend_d = 1'b0;
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      vaddr_q      <= '0;
      rr_ptr_q     <= '0;
      flush_pend_q <= 1'b0;
      resp_paddr_q <= '0;
      walk_vaddr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      rr_ptr_q     <= rr_ptr_d;
      flush_pend_q <= flush_pend_d;
      resp_paddr_q <= resp_paddr_d;
      walk_vaddr_q <= walk_vaddr_d;
      entries_q    <= entries_d;
    end
  end

  assign bus.resp_valid     = (state_q == StDone);
  assign bus.resp_paddr     = resp_paddr_q;
  assign bus.walk_req_valid = (state_q == StWreq);
  assign bus.walk_vaddr     = walk_vaddr_q;

endmodule
